// File: rtl/p2s_sched_pkg.sv
// Shared state type and frame-geometry helpers for p2s_rr_scheduler.
// Building with P2S_SCHED_PARITY_EN appends an even-parity bit to every frame.
package p2s_sched_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

`ifdef P2S_SCHED_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEFAULT_DATA_W = 4;
  localparam int FRAME_LEN      = DEFAULT_DATA_W + PARITY_BITS;

  function automatic int frame_len(input int data_w);
    return data_w + PARITY_BITS;
  endfunction

  function automatic int cnt_width(input int flen);
    return $clog2(flen + 1);
  endfunction

endpackage

// File: rtl/p2s_rr_scheduler_rr_arbiter.sv
// Combinational round-robin search: requests at or above the pointer win first,
// otherwise the lowest requester overall wins (wrap-around).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] masked;
  logic               found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked[gi] = req_i[gi] & (IDX_W'(gi) >= ptr_i);
    end
  endgenerate

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && masked[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one LSB-first parallel-to-serial shifter among NUM_REQ requesters.
// Optional P2S_SCHED_PARITY_EN appends an even-parity bit after the MSB of each frame.
module p2s_rr_scheduler
  import p2s_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       serial_o,
  output logic                       valid_o,
  output logic                       last_o,
  output logic                       empty_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int FLEN  = frame_len(DATA_W);
  localparam int CNT_W = cnt_width(FLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLEN - 1);

  logic [DATA_W-1:0] words [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign words[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [FLEN-2:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              serial_q, serial_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              empty_q, empty_d;

  logic              window;
  logic              accept;
  logic [IDX_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] word_sel;
  logic [FLEN-1:0]   frame;

  // The last-bit cycle doubles as an accept slot so frames run back to back.
  assign window = (state_q == IDLE) || (cnt_q == CNT_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .en_i  (window),
    .gnt_o (gnt_o),
    .idx_o (gnt_idx)
  );

  assign accept   = |gnt_o;
  assign word_sel = words[gnt_idx];
`ifdef P2S_SCHED_PARITY_EN
  assign frame = {^word_sel, word_sel};
`else
  assign frame = word_sel;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    valid_d  = valid_q;
    last_d   = last_q;
    empty_d  = empty_q;
    if (accept) begin
      // Bit 0 goes straight to the output register; the rest waits in the shifter.
      serial_d = frame[0];
      shreg_d  = frame[FLEN-1:1];
      owner_d  = gnt_idx;
      ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      cnt_d    = '0;
      valid_d  = 1'b1;
      last_d   = 1'b0;
      empty_d  = 1'b0;
      state_d  = SHIFT;
    end else if (state_q == SHIFT) begin
      if (cnt_q == CNT_LAST) begin
        state_d  = IDLE;
        serial_d = 1'b0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        empty_d  = 1'b1;
        cnt_d    = '0;
      end else begin
        serial_d = shreg_q[0];
        shreg_d  = shreg_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        last_d   = ((cnt_q + CNT_W'(1)) == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      empty_q  <= empty_d;
    end
  end

  assign owner_o  = owner_q;
  assign serial_o = serial_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign empty_o  = empty_q;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Scoreboard bench for p2s_rr_scheduler: stimulus queues expected grants and frame bits,
// a negedge monitor pops and compares whenever the DUT grants or presents a valid bit.
module tb_p2s_rr_scheduler;

`ifdef P2S_SCHED_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_i = '0;
  logic [15:0] data_i = '0;
  logic [3:0]  gnt_o;
  logic [1:0]  owner_o;
  logic        serial_o, valid_o, last_o, empty_o;

  p2s_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .data_i   (data_i),
    .gnt_o    (gnt_o),
    .owner_o  (owner_o),
    .serial_o (serial_o),
    .valid_o  (valid_o),
    .last_o   (last_o),
    .empty_o  (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       serial;
    logic       last;
    logic [1:0] owner;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] gnt_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] w, input logic [1:0] own);
    logic [4:0] fw;
    exp_t e;
    fw = {^w, w};
    for (int i = 0; i < FL; i++) begin
      e.serial = fw[i];
      e.last   = (i == FL - 1);
      e.owner  = own;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    gnt_q.delete();
  endtask

  task automatic end_check(input string name);
    chk(name, exp_q.size() + gnt_q.size(), 0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gnt_o != 4'b0000) begin
          if (gnt_q.size() == 0) chk("unexpected_gnt", {28'b0, gnt_o}, 0);
          else                   chk("gnt", {28'b0, gnt_o}, {28'b0, gnt_q.pop_front()});
        end
        if (valid_o) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("frame_bit", {28'b0, serial_o, last_o, owner_o}, {28'b0, e.serial, e.last, e.owner});
            chk("empty_in_frame", {31'b0, empty_o}, 0);
          end
        end else begin
          chk("idle_outputs", {29'b0, last_o, serial_o, empty_o}, 32'h1);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    // Reset state
    @(negedge clk);
    chk("reset_state", {27'b0, serial_o, valid_o, last_o, empty_o, owner_o}, 32'h04);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single request, word2 = 1010 -> bits 0,1,0,1; data and X req after grant ignored
    data_i = 16'h0A00;
    req_i  = 4'b0100;
    gnt_q.push_back(4'b0100);
    push_frame(4'b1010, 2'd2);
    @(posedge clk); #1;
    req_i  = 'x;
    data_i = 16'hFFFF;
    repeat (FL - 2) @(posedge clk);
    #1;
    req_i = '0;
    repeat (FL + 2) @(posedge clk);
    #1;
    end_check("single_drained");

    // All requesting: grants 0,1,2,3,0 with no bubble
    do_reset();
    data_i = 16'h8421;
    req_i  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back(4'b0001 << (i % 4));
      push_frame(4'b0001 << (i % 4), 2'(i % 4));
    end
    s0 = valid_cnt;
    repeat (4 * FL + 1) @(posedge clk);
    #1;
    req_i = '0;
    repeat (FL - 1) @(posedge clk);
    @(negedge clk); #1;
    chk("no_bubble_valid_cycles", valid_cnt - s0, 5 * FL);
    repeat (3) @(posedge clk);
    #1;
    end_check("allreq_drained");

    // Requester 1 withdraws, 3 arrives: next grant goes to 3
    do_reset();
    data_i = 16'h6005;
    req_i  = 4'b0011;
    gnt_q.push_back(4'b0001);
    push_frame(4'h5, 2'd0);
    gnt_q.push_back(4'b1000);
    push_frame(4'h6, 2'd3);
    @(posedge clk); #1;
    req_i = 4'b1000;
    repeat (FL) @(posedge clk);
    #1;
    req_i = '0;
    repeat (FL + 2) @(posedge clk);
    #1;
    end_check("withdraw_drained");

    // Reset mid-frame: outputs drop asynchronously, pointer back to 0
    do_reset();
    data_i = 16'h000F;
    req_i  = 4'b0001;
    gnt_q.push_back(4'b0001);
    push_frame(4'hF, 2'd0);
    @(posedge clk); #1;
    req_i = '0;
    @(posedge clk); #7;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {28'b0, serial_o, valid_o, last_o, empty_o}, 32'h1);
    exp_q.delete();
    gnt_q.delete();
    @(posedge clk); #1;
    reset  = 1'b0;
    data_i = 16'h3C5A;
    req_i  = 4'b1111;
    gnt_q.push_back(4'b0001);
    push_frame(4'hA, 2'd0);
    @(posedge clk); #1;
    req_i = '0;
    repeat (FL + 2) @(posedge clk);
    #1;
    end_check("post_reset_drained");

    // Words 1011 and 1001 (parity 1 and 0 when the parity bit is enabled)
    data_i = 16'h09B0;
    req_i  = 4'b0010;
    gnt_q.push_back(4'b0010);
    push_frame(4'b1011, 2'd1);
    @(posedge clk); #1;
    req_i = '0;
    repeat (FL + 2) @(posedge clk);
    #1;
    req_i = 4'b0100;
    gnt_q.push_back(4'b0100);
    push_frame(4'b1001, 2'd2);
    @(posedge clk); #1;
    req_i = '0;
    repeat (FL + 2) @(posedge clk);
    #1;
    end_check("parity_words_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/p2s_rr_scheduler.md
Name: p2s_rr_scheduler

Overview:
- Shares one parallel-to-serial shift datapath between NUM_REQ requesters.
- A round-robin arbiter picks a requester and captures its parallel word, then shifts the word out LSB-first as a framed serial stream.
- Sits between multiple word producers and a single serial link; back-to-back frames run with no idle bubble.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 4, bits per parallel word (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request level; held until granted.
- data_i  in  NUM_REQ*DATA_W  packed words; requester r owns bits [r*DATA_W +: DATA_W].
- gnt_o  out  NUM_REQ  one-hot accept strobe (combinational); data sampled at end of this cycle.
- owner_o  out  $clog2(NUM_REQ)  index of requester whose frame is being shifted (registered).
- serial_o  out  1  serial data bit (registered).
- valid_o  out  1  serial_o carries a frame bit (registered).
- last_o  out  1  final bit of current frame (registered).
- empty_o  out  1  no unsent bits in the shifter (registered).

Behaviour:
- Reset (async assert, sync release) sets serial_o=0, valid_o=0, last_o=0, empty_o=1, owner_o=0, rr pointer=0, state IDLE, bit counter=0. Asserting reset mid-frame aborts the frame immediately; no partial-frame resume.
- States: IDLE and SHIFT.
- Accept window: in IDLE, or in SHIFT during the cycle that outputs the frame's last bit.
  - Only in the window may gnt_o be nonzero.
  - gnt_o[r]=1 iff r is the first requester with req_i high, searching from pointer upward with wrap-around.
- On an accepting edge:
  - the shifter loads data_i word r; owner_o<=r; pointer<=(r+1) mod NUM_REQ;
  - state<=SHIFT; counter<=0.
- Latency and frame timing: with gnt_o[r] in cycle k, frame bits appear in cycles k+1..k+FRAME_LEN.
  - FRAME_LEN=DATA_W, or DATA_W+1 with the optional feature.
  - Bit order is LSB first.
  - valid_o=1 and empty_o=0 throughout the frame; last_o=1 only in cycle k+FRAME_LEN.
- Frame end:
  - If another accept occurs in the last-bit cycle, the next frame starts the following cycle with no gap (valid_o stays 1).
  - Otherwise state<=IDLE; valid_o, last_o and serial_o go 0; empty_o goes 1.
- Request handling:
  - A requester that drops req_i before being granted is simply skipped; requests are not latched.
  - The owner holding req_i after its grant counts as a new request, subject to round-robin order.
- Fairness: with all req_i held high, grants go 0,1,2,...,NUM_REQ-1,0,...
- Input checks: data_i changes after the grant cycle do not affect the frame in flight. An X on req_i outside the accept window is ignored.
- Counter width is $clog2(FRAME_LEN+1); the counter saturates at FRAME_LEN-1 and never wraps mid-frame.

Optional Feature:
- Macro P2S_SCHED_PARITY_EN.
- Defined: an even-parity bit (XOR of the DATA_W data bits) is appended after the MSB. FRAME_LEN=DATA_W+1; last_o marks the parity bit; the accept window moves to the parity-bit cycle.
- Undefined: no parity bit; FRAME_LEN=DATA_W; last_o marks the MSB.

Decomposition:
- Package p2s_sched_pkg holds:
  - state enum (IDLE, SHIFT);
  - localparam FRAME_LEN derived under the macro;
  - function for counter width.
- Sub-module rr_arbiter holds:
  - purely combinational masked-priority search, taking req, pointer and enable;
  - outputs one-hot gnt and encoded index.
- The top holds the pointer register, shifter, counter and FSM.

Test Plan:
- Single request: NUM_REQ=4, DATA_W=4; req_i=4'b0100, data word2=4'b1010 in IDLE.
  - Required: gnt_o=4'b0100 in the same cycle.
  - Then serial_o=0,1,0,1 over the next 4 cycles, with valid_o=1, last_o on the 4th, owner_o=2.
  - Then empty_o=1.
- All requesting: req_i=4'b1111 held, words 0..3 = 4'h1,4'h2,4'h4,4'h8.
  - Required: grants 0,1,2,3,0 at 4-cycle spacing; valid_o continuously 1 (no bubble).
- Requester withdraws: req_i=4'b0011 held for a grant to 0; then req1 drops during frame 0 while req3 rises.
  - Required: next grant goes to 3, not 1.
- Reset mid-frame: assert reset 2 cycles into a frame of 4'b1111.
  - Required: serial_o/valid_o/last_o drop to 0 and empty_o rises to 1 without waiting for a clock edge.
  - After release, the first grant goes to the lowest requester (pointer=0).
- Parity build (P2S_SCHED_PARITY_EN), word 4'b1011:
  - Required: 5-bit frame 1,1,0,1,1, with last_o on the 5th bit.
  - Word 4'b1001 gives parity bit 0.
